// File: rtl/rx_pkg.sv
// Shared types and default parameters for the receive bank buffer.
package rx_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 8;
    localparam int NUM_BANKS_DEF = 2;
    localparam int FRAME_LEN_DEF = 256;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_t;

    typedef enum logic {W_FILL, W_WAIT} wr_state_t;
    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

endpackage

// File: rtl/rx_bank_ram.sv
// Simple dual-port bank RAM: one write port, one synchronous read port with enable.
module rx_bank_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rx_bank_buffer.sv
// Multi-bank receive buffer: a writer fills banks in rotation, a reader hands
// full banks to the DSP in the same order and frees them on frame_done.
module rx_bank_buffer
    import rx_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         frame_valid,
    output logic [$clog2(NUM_BANKS)-1:0] frame_bank,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         frame_done,
    output logic                         overflow
);

    localparam int                BANK_W   = $clog2(NUM_BANKS);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(FRAME_LEN - 1);
    localparam logic [BANK_W-1:0] TOP_BANK = BANK_W'(NUM_BANKS - 1);

    bank_state_t       bank_state [NUM_BANKS];
    bank_state_t       bank_next  [NUM_BANKS];
    wr_state_t         w_state, w_next;
    rd_state_t         r_state, r_next;
    logic [BANK_W-1:0] w_bank, w_bank_next, w_bank_inc;
    logic [BANK_W-1:0] r_bank, r_bank_next, r_bank_inc;
    logic [BANK_W-1:0] frame_bank_next;
    logic [ADDR_W-1:0] count, count_next;
    logic              accept;
    logic [DATA_W-1:0] bank_q [NUM_BANKS];

    assign in_ready    = (w_state == W_FILL);
    assign frame_valid = (r_state == R_BUSY);
    assign accept      = in_valid && in_ready;
    assign w_bank_inc  = (w_bank == TOP_BANK) ? '0 : w_bank + 1'b1;
    assign r_bank_inc  = (r_bank == TOP_BANK) ? '0 : r_bank + 1'b1;

    // Writer and reader only ever touch banks in disjoint states, so their
    // bank_next updates never collide.
    always_comb begin
        // NOTE: every next-state variable takes its hold value first so no path infers a latch.
        bank_next       = bank_state;
        w_next          = w_state;
        w_bank_next     = w_bank;
        count_next      = count;
        r_next          = r_state;
        r_bank_next     = r_bank;
        frame_bank_next = frame_bank;

        if (w_state == W_FILL) begin
            if (accept) begin
                if (count == LAST) begin
                    count_next        = '0;
                    bank_next[w_bank] = BANK_FULL;
                    w_bank_next       = w_bank_inc;
                    if (bank_state[w_bank_inc] == BANK_FREE) bank_next[w_bank_inc] = BANK_FILLING;
                    else                                     w_next = W_WAIT;
                end else begin
                    count_next = count + 1'b1;
                end
            end
        end else if (bank_state[w_bank] == BANK_FREE) begin
            bank_next[w_bank] = BANK_FILLING;
            w_next            = W_FILL;
        end

        if (r_state == R_IDLE) begin
            if (bank_state[r_bank] == BANK_FULL) begin
                bank_next[r_bank] = BANK_READING;
                frame_bank_next   = r_bank;
                r_next            = R_BUSY;
            end
        end else if (frame_done) begin
            bank_next[r_bank] = BANK_FREE;
            r_bank_next       = r_bank_inc;
            r_next            = R_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++)
                bank_state[i] <= (i == 0) ? BANK_FILLING : BANK_FREE;
            w_state    <= W_FILL;
            r_state    <= R_IDLE;
            w_bank     <= '0;
            r_bank     <= '0;
            count      <= '0;
            frame_bank <= '0;
            overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            bank_state <= bank_next;
            w_state    <= w_next;
            r_state    <= r_next;
            w_bank     <= w_bank_next;
            r_bank     <= r_bank_next;
            count      <= count_next;
            frame_bank <= frame_bank_next;
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        rx_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (accept && (w_bank == BANK_W'(i))),
            .wr_addr (count),
            .wr_data (in_data),
            .rd_en   (frame_valid && (frame_bank == BANK_W'(i))),
            .rd_addr (rd_addr),
            .rd_data (bank_q[i])
        );
    end

    assign rd_data = bank_q[frame_bank];

endmodule

// File: tb/tb_rx_bank_buffer.sv
// Directed bench: a 2-bank and a 4-bank instance, FRAME_LEN=4, hand-computed expectations.
module tb_rx_bank_buffer;

    logic        clk = 1'b0;
    logic        rst;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic        in_valid, frame_done, in_ready, frame_valid, overflow;
    logic [15:0] in_data, rd_data;
    logic [0:0]  frame_bank;
    logic [2:0]  rd_addr;

    logic        in_valid4, frame_done4, in_ready4, frame_valid4, overflow4;
    logic [15:0] in_data4, rd_data4;
    logic [1:0]  frame_bank4;
    logic [2:0]  rd_addr4;

    always #5 clk = ~clk;

    rx_bank_buffer #(.DATA_W(16), .ADDR_W(3), .NUM_BANKS(2), .FRAME_LEN(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .frame_valid(frame_valid), .frame_bank(frame_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .overflow(overflow)
    );

    rx_bank_buffer #(.DATA_W(16), .ADDR_W(3), .NUM_BANKS(4), .FRAME_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .frame_valid(frame_valid4), .frame_bank(frame_bank4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .frame_done(frame_done4), .overflow(overflow4)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] v, input logic done);
        in_valid = 1'b1; in_data = v; frame_done = done;
        step();
        in_valid = 1'b0; frame_done = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; frame_done = 1'b0; rd_addr = '0;
        in_valid4 = 1'b0; in_data4 = '0; frame_done4 = 1'b0; rd_addr4 = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
        tests_run++; if (frame_bank !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_bank: got %0d want 0", frame_bank); end
        tests_run++; if (rd_data !== 16'd0) begin tests_failed++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    // Push 1..4, frame presented one cycle after completion, read back, release.
    task automatic test_single_frame();
        do_reset();
        for (int i = 1; i <= 4; i++) push(16'(i), 1'b0);
        tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL sf_valid_early: got %b want 0", frame_valid); end
        step();
        tests_run++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin tests_failed++; $display("FAIL sf_present: got valid=%b bank=%0d want valid=1 bank=0", frame_valid, frame_bank); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL sf_in_ready: got %b want 1", in_ready); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 1)) begin tests_failed++; $display("FAIL sf_read%0d: got %0d want %0d", a, rd_data, a + 1); end
        end
        pulse_done();
        rd_addr = 3'd0;
        step();
        tests_run++; if (frame_valid !== 1'b0 || rd_data !== 16'd4) begin tests_failed++; $display("FAIL sf_release_hold: got valid=%b data=%0d want valid=0 data=4", frame_valid, rd_data); end
    endtask

    // Fill both banks, overflow on sample 9, then drain with writer resume into bank 0.
    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) push(16'(i), 1'b0);
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL ov_in_ready: got %b want 0", in_ready); end
        push(16'd9, 1'b0);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ov_flag: got %b want 1", overflow); end
        pulse_done();
        tests_run++; if (in_ready !== 1'b0 || frame_valid !== 1'b0) begin tests_failed++; $display("FAIL ov_after_done: got ready=%b valid=%b want ready=0 valid=0", in_ready, frame_valid); end
        step();
        tests_run++; if (in_ready !== 1'b1 || frame_valid !== 1'b1 || frame_bank !== 1'b1) begin tests_failed++; $display("FAIL ov_resume: got ready=%b valid=%b bank=%0d want 1 1 1", in_ready, frame_valid, frame_bank); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 5)) begin tests_failed++; $display("FAIL ov_bank1_read%0d: got %0d want %0d", a, rd_data, a + 5); end
        end
        for (int i = 10; i <= 13; i++) push(16'(i), 1'b0);
        pulse_done();
        step();
        tests_run++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin tests_failed++; $display("FAIL ov_bank0_present: got valid=%b bank=%0d want 1 0", frame_valid, frame_bank); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 10)) begin tests_failed++; $display("FAIL ov_bank0_read%0d: got %0d want %0d", a, rd_data, a + 10); end
        end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ov_sticky: got %b want 1", overflow); end
    endtask

    // Release of bank 0 coincides with completion of bank 1.
    task automatic test_collision();
        do_reset();
        for (int i = 1; i <= 7; i++) push(16'(i), 1'b0);
        push(16'd8, 1'b1);
        tests_run++; if (in_ready !== 1'b0 || frame_valid !== 1'b0) begin tests_failed++; $display("FAIL col_wait: got ready=%b valid=%b want 0 0", in_ready, frame_valid); end
        step();
        tests_run++; if (in_ready !== 1'b1 || frame_valid !== 1'b1 || frame_bank !== 1'b1) begin tests_failed++; $display("FAIL col_resume: got ready=%b valid=%b bank=%0d want 1 1 1", in_ready, frame_valid, frame_bank); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 5)) begin tests_failed++; $display("FAIL col_bank1_read%0d: got %0d want %0d", a, rd_data, a + 5); end
        end
        for (int i = 9; i <= 12; i++) push(16'(i), 1'b0);
        pulse_done();
        step();
        tests_run++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin tests_failed++; $display("FAIL col_third_frame: got valid=%b bank=%0d want 1 0", frame_valid, frame_bank); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 9)) begin tests_failed++; $display("FAIL col_bank0_read%0d: got %0d want %0d", a, rd_data, a + 9); end
        end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL col_no_drop: got overflow=%b want 0", overflow); end
    endtask

    // Asynchronous reset with a frame presented and a partial frame pending.
    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) push(16'(i), 1'b0);
        step();
        rd_addr = 3'd1;
        step();
        push(16'd51, 1'b0);
        push(16'd52, 1'b0);
        rst = 1'b1;
        #1;
        tests_run++; if (frame_valid !== 1'b0 || rd_data !== 16'd0 || in_ready !== 1'b1 || frame_bank !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++; $display("FAIL rm_async: got valid=%b data=%0d ready=%b bank=%0d ovf=%b want 0 0 1 0 0", frame_valid, rd_data, in_ready, frame_bank, overflow);
        end
        step();
        rst = 1'b0;
        for (int i = 61; i <= 64; i++) push(16'(i), 1'b0);
        step();
        tests_run++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin tests_failed++; $display("FAIL rm_frame: got valid=%b bank=%0d want 1 0", frame_valid, frame_bank); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 61)) begin tests_failed++; $display("FAIL rm_read%0d: got %0d want %0d", a, rd_data, a + 61); end
        end
    endtask

    // frame_done with nothing presented must not disturb filling.
    task automatic test_done_idle();
        do_reset();
        pulse_done();
        tests_run++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL di_idle: got valid=%b ready=%b want 0 1", frame_valid, in_ready); end
        push(16'd71, 1'b0);
        push(16'd72, 1'b0);
        pulse_done();
        push(16'd73, 1'b0);
        push(16'd74, 1'b0);
        step();
        tests_run++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin tests_failed++; $display("FAIL di_frame: got valid=%b bank=%0d want 1 0", frame_valid, frame_bank); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 3'(a);
            step();
            tests_run++; if (rd_data !== 16'(a + 71)) begin tests_failed++; $display("FAIL di_read%0d: got %0d want %0d", a, rd_data, a + 71); end
        end
    endtask

    // Four banks filled back to back, consumed in order 0,1,2,3.
    task automatic test_four_banks();
        int not_ready;
        do_reset();
        not_ready = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid4 = 1'b1; in_data4 = 16'(100 + i);
            if (in_ready4 !== 1'b1) not_ready++;
            step();
        end
        in_valid4 = 1'b0;
        tests_run++; if (not_ready != 0 || overflow4 !== 1'b0) begin tests_failed++; $display("FAIL fb_accept: got %0d refused ovf=%b want 0 0", not_ready, overflow4); end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                frame_done4 = 1'b1;
                step();
                frame_done4 = 1'b0;
                tests_run++; if (frame_valid4 !== 1'b0) begin tests_failed++; $display("FAIL fb_gap%0d: got valid=%b want 0", k, frame_valid4); end
                step();
            end
            tests_run++; if (frame_valid4 !== 1'b1 || frame_bank4 !== 2'(k)) begin tests_failed++; $display("FAIL fb_order%0d: got valid=%b bank=%0d want 1 %0d", k, frame_valid4, frame_bank4, k); end
            rd_addr4 = 3'd3;
            step();
            tests_run++; if (rd_data4 !== 16'(100 + 4 * k + 3)) begin tests_failed++; $display("FAIL fb_read%0d: got %0d want %0d", k, rd_data4, 100 + 4 * k + 3); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_collision();
        test_reset_mid();
        test_done_idle();
        test_four_banks();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_bank_buffer.md
RX_BANK_BUFFER -- requirements
Module: rx_bank_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning per-bank address width; bank depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_BANKS, default 2, legal 2..4, meaning number of data memory banks.
REQ-004 The block SHALL have parameter FRAME_LEN, default 256, legal 1..2**ADDR_W, meaning samples per frame.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high; the ports are clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-006 The block SHALL have port in_valid (in, 1): a sample is offered.
REQ-007 The block SHALL have port in_data (in, DATA_W): the sample value.
REQ-008 The block SHALL have port in_ready (out, 1): the block accepts the sample this cycle.
REQ-009 The block SHALL have port frame_valid (out, 1): a full bank is presented to the DSP.
REQ-010 The block SHALL have port frame_bank (out, clog2(NUM_BANKS)): the index of the presented bank.
REQ-011 The block SHALL have port rd_addr (in, ADDR_W): the DSP read address in the presented bank.
REQ-012 The block SHALL have port rd_data (out, DATA_W): the read data.
REQ-013 The block SHALL have port frame_done (in, 1): a one-cycle pulse by which the DSP releases the presented bank.
REQ-014 The block SHALL have port overflow (out, 1): sticky flag for a sample that was dropped.

Function
REQ-015 Each bank SHALL hold a registered state: FREE, FILLING, FULL or READING.
REQ-016 Writer FSM SHALL have states W_FILL and W_WAIT. A sample is accepted when in_valid and in_ready are both 1. Each accepted sample is written at the write count in the write bank, and the count then increments.
REQ-017 On the sample that makes the count equal FRAME_LEN, the write bank SHALL become FULL and the count SHALL return to 0. The writer then moves to bank (w_bank+1) mod NUM_BANKS: if that bank is FREE, it becomes FILLING in the next cycle; otherwise the writer enters W_WAIT.
REQ-018 in_ready SHALL equal 1 exactly in W_FILL. In W_WAIT the writer polls the registered state of the next bank and returns to W_FILL the cycle after that bank reads FREE.
REQ-019 in_valid=1 with in_ready=0 SHALL drop the sample and set overflow, which stays set until rst.
REQ-020 Reader FSM SHALL have states R_IDLE and R_BUSY. From R_IDLE, if bank r_bank is FULL, the reader marks it READING and asserts frame_valid with frame_bank=r_bank in the next cycle.
REQ-021 Banks SHALL be consumed strictly in write order (r_bank increments mod NUM_BANKS), never skipped.
REQ-022 rd_data SHALL be the contents of presented bank at rd_addr, registered with 1-cycle latency; rd_data holds its last value when frame_valid=0.
REQ-023 frame_done while frame_valid=1 SHALL free the bank, deassert frame_valid in the next cycle and return the reader to R_IDLE. A freed bank is presented again no earlier than 1 cycle after release.
REQ-024 frame_done while frame_valid=0 SHALL be ignored.
REQ-025 A frame_done that frees bank k in the same cycle the writer completes into a wait on bank k SHALL be handled as follows: the writer sees FREE in the next cycle and resumes one cycle later, with no sample lost or duplicated.
REQ-026 The write count wraps at FRAME_LEN, not at 2**ADDR_W; addresses at or above FRAME_LEN are never written.

Reset
REQ-027 rst SHALL force: all banks FREE except bank 0 FILLING; w_bank=0; r_bank=0; count=0; W_FILL; R_IDLE; in_ready=1; frame_valid=0; frame_bank=0; rd_data=0; overflow=0.
REQ-028 Reset mid-frame SHALL discard partial and pending frames; RAM contents are not cleared.

Structure
REQ-029 Package rx_pkg SHALL hold the bank-state enum, the writer and reader FSM enums, and the default parameter constants.
REQ-030 Sub-module rx_bank_ram SHALL be one simple dual-port RAM (1 write port, 1 synchronous read port, DATA_W x 2**ADDR_W), instantiated NUM_BANKS times; read data is muxed by frame_bank.

Verification (NUM_BANKS=2, FRAME_LEN=4, DATA_W=16)
REQ-031 Push 1,2,3,4 -> frame_valid=1, frame_bank=0; rd_addr 0..3 gives 1..4 one cycle later each.
REQ-032 Push 8 samples with no frame_done -> 9th sample sees in_ready=0; offering it sets overflow=1 and drops it; bank 1 reads 5..8.
REQ-033 With both banks full, pulse frame_done -> bank 1 presented next; writer resumes into bank 0 after 2 cycles; samples 10..13 are stored intact.
REQ-034 frame_done in the same cycle the writer completes bank 1 -> no drop; ordering is 0,1,0 for frame_bank.
REQ-035 Assert rst after 2 samples of frame 0 -> all outputs return to reset values; next 4 samples form a complete frame in bank 0.
REQ-036 frame_done while frame_valid=0 -> no state change; NUM_BANKS=4 run of 16 samples shows frame_bank sequence 0,1,2,3.
